rdma_ctyun_sdpram_fifo_ctrl: RTL
================================

# rdma_ctyun_sdpram_fifo_ctrl

Synchronous FIFO controller that owns one simple-dual-port RAM instance: it drives the RAM write port from an upstream valid/ready stream, issues RAM reads, and absorbs the RAM's 1- or 2-cycle read latency into a small prefetch buffer. The result is a zero-bubble, show-ahead valid/ready stream downstream. It sits between RDMA packet/descriptor producers and consumers wherever a block-RAM-backed queue is needed. The RAM itself is instantiated beside it, with matching address/data widths and the same READ_LATENCY.

## Interface
- ADDR_WIDTH, 8, RAM address width; RAM depth DEPTH = 2^ADDR_WIDTH.
- DATA_WIDTH, 32, stream and RAM word width (read width = write width).
- READ_LATENCY, 2, RAM read latency in cycles; legal values 1 or 2 only.
- clock  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  upstream ready (registered).
- s_data  in  DATA_WIDTH  upstream word.
- m_valid  out  1  downstream word valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  downstream word (head of prefetch buffer).
- ram_wren  out  1  RAM write enable.
- ram_wraddress  out  ADDR_WIDTH  RAM write address.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_byteena  out  (DATA_WIDTH+7)/8  constant all-ones.
- ram_rden  out  1  RAM read enable.
- ram_rdaddress  out  ADDR_WIDTH  RAM read address.
- ram_dout  in  DATA_WIDTH  RAM read data, valid READ_LATENCY cycles after the issue cycle.
- count  out  ADDR_WIDTH+2  total words held: RAM + in flight + prefetch buffer.

## Operation
**Write side**
- push = s_valid & s_ready.
- ram_wren = push, ram_din = s_data, ram_wraddress = wptr. All three are combinational from the inputs and registered wptr.
- wptr increments on push and wraps modulo DEPTH.

**RAM occupancy**
- ram_cnt (ADDR_WIDTH+1 bits) = words written to the RAM and not yet read-issued.
- ram_cnt_next = ram_cnt + push - issue.

**Read issue**
- issue = (ram_cnt != 0) & (inflight + ob_cnt - pop < OB_DEPTH).
- OB_DEPTH = READ_LATENCY + 1.
- pop = m_valid & m_ready.
- ram_rden = issue, ram_rdaddress = rptr. rptr increments on issue and wraps modulo DEPTH.
- A word written in cycle t is first issuable in cycle t+1. The RAM is therefore never read at an address written in the same cycle, and the read-during-write mode is irrelevant.

**Return path**
- A READ_LATENCY-deep valid shift register tracks in-flight reads. inflight = its population count.
- When the shift register's output bit is 1, ram_dout is written into the prefetch buffer in that cycle.

**Prefetch buffer**
- OB_DEPTH-entry register FIFO. m_valid = (ob_cnt != 0); m_data = head entry.
- Write and pop in the same cycle are both honoured. The credit rule guarantees the buffer never overflows.

**Ready and count**
- s_ready is a register: s_ready <= (ram_cnt_next < DEPTH).
- count = ram_cnt + inflight + ob_cnt. Maximum value is DEPTH + OB_DEPTH.

**Reset**
- Asynchronous assertion clears wptr, rptr, ram_cnt, the valid shift register, ob_cnt and s_ready. RAM contents are not cleared.
- Read data returning after a mid-operation reset is discarded because the shift register is cleared.

## Timing
- Reset values: s_ready 0, m_valid 0, count 0, ram_wren 0 (s_valid is ignored while s_ready=0), ram_rden 0.
- s_ready rises on the first clock edge after reset_n deasserts.
- Fall-through latency: a push in cycle 0 issues a read in cycle 1. ram_dout is valid in cycle 1+READ_LATENCY, and m_valid=1 in cycle 2+READ_LATENCY (cycle 4 for READ_LATENCY=2, cycle 3 for 1).
- Throughput: one word per cycle sustained in both directions with continuous s_valid and m_ready.
- Full: after DEPTH words sit in the RAM, s_ready=0 in the following cycle. A push in the same cycle as the filling push cannot occur because s_ready is registered. s_ready returns to 1 the cycle after any issue that lowers ram_cnt_next below DEPTH.
- Empty: with ram_cnt=0 no issue occurs. m_valid stays 1 until the buffer drains.
- Back-pressure: while m_valid=1 and m_ready=0, m_data is held stable.
- A simultaneous push and issue at ram_cnt=DEPTH keeps ram_cnt=DEPTH. At ram_cnt=1 the result is ram_cnt=1.
- Pointer wrap: address DEPTH-1 is followed by address 0 with no gap.

## Test plan
- **Reset/latency, READ_LATENCY=2:** release reset, push 0xA5 in cycle 0 -> s_ready=1 at first edge, ram_rden in cycle 1 with rdaddress 0, m_valid in cycle 4 with m_data 0xA5, count 1 from cycle 1 until pop.
- **Fill to full, ADDR_WIDTH=4, m_ready=0:** push 1..30 -> s_ready drops after 16+3=19 words accepted (16 in RAM, 3 prefetched), count=19, no further ram_wren.
- **Streaming with wrap:** push 0..999 continuously, m_ready=1 -> output 0..999 in order with no bubbles after the initial latency, ram_wraddress wrapping 15->0 repeatedly.
- **Random valid/ready:** random s_valid/m_ready at 50% each, 5000 words, both READ_LATENCY=1 and 2 -> scoreboard match and count equal to pushed minus popped every cycle.
- **Back-pressure stability:** m_valid=1, hold m_ready=0 for 10 cycles -> m_data unchanged, ram_rden=0 once the credit is exhausted.
- **Mid-operation reset:** assert reset_n=0 with 2 reads in flight -> m_valid, count, s_ready=0 immediately. After release, the next pushed word 0x77 is the first word output.

Source files
------------

// File: rtl/rdma_ctyun_sdpram_fifo_ctrl.sv
// FIFO controller around an external simple-dual-port RAM. Absorbs the RAM
// read latency with a small prefetch buffer so the downstream side sees a
// show-ahead, zero-bubble valid/ready stream.
module rdma_ctyun_sdpram_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_WIDTH-1:0]       s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        ram_wren,
  output logic [ADDR_WIDTH-1:0]       ram_wraddress,
  output logic [DATA_WIDTH-1:0]       ram_din,
  output logic [(DATA_WIDTH+7)/8-1:0] ram_byteena,
  output logic                        ram_rden,
  output logic [ADDR_WIDTH-1:0]       ram_rdaddress,
  input  logic [DATA_WIDTH-1:0]       ram_dout,
  output logic [ADDR_WIDTH+1:0]       count
);

  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam int unsigned OB_DEPTH = READ_LATENCY + 1;
  localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
  localparam int unsigned TOT_W    = ADDR_WIDTH + 2;
  localparam int unsigned IF_W     = $clog2(READ_LATENCY + 1);
  localparam int unsigned OBP_W    = $clog2(OB_DEPTH);
  localparam int unsigned OBC_W    = $clog2(OB_DEPTH + 1);
  localparam int unsigned CR_W     = 3;

  logic [ADDR_WIDTH-1:0]   wptr;
  logic [ADDR_WIDTH-1:0]   rptr;
  logic [CNT_W-1:0]        ram_cnt;
  logic [CNT_W-1:0]        ram_cnt_next;
  logic [READ_LATENCY-1:0] vld_sr;
  logic [IF_W-1:0]         inflight;
  logic [DATA_WIDTH-1:0]   ob_mem [OB_DEPTH];
  logic [OBP_W-1:0]        ob_wp;
  logic [OBP_W-1:0]        ob_rp;
  logic [OBC_W-1:0]        ob_cnt;
  logic [CR_W-1:0]         credit_used;
  logic                    push;
  logic                    pop;
  logic                    issue;
  logic                    ob_wr;

  assign push          = s_valid & s_ready;
  assign pop           = m_valid & m_ready;
  assign ram_wren      = push;
  assign ram_din       = s_data;
  assign ram_wraddress = wptr;
  assign ram_byteena   = '1;
  assign ram_rden      = issue;
  assign ram_rdaddress = rptr;
  assign m_valid       = (ob_cnt != '0);
  assign m_data        = ob_mem[ob_rp];
  assign ob_wr         = vld_sr[READ_LATENCY-1];

  // Number of reads currently travelling through the RAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      inflight = inflight + IF_W'(vld_sr[i]);
    end
  end

  // Only issue a read when the prefetch buffer is guaranteed a free slot on return.
  always_comb begin
    credit_used  = CR_W'(inflight) + CR_W'(ob_cnt) - CR_W'(pop);
    issue        = (ram_cnt != '0) && (credit_used < CR_W'(OB_DEPTH));
    ram_cnt_next = ram_cnt + CNT_W'(push) - CNT_W'(issue);
    count        = TOT_W'(ram_cnt) + TOT_W'(inflight) + TOT_W'(ob_cnt);
  end

  // Write/read pointers, RAM occupancy, registered upstream ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      s_ready <= 1'b0;
    end else begin
      if (push) wptr <= wptr + ADDR_WIDTH'(1);
      if (issue) rptr <= rptr + ADDR_WIDTH'(1);
      ram_cnt <= ram_cnt_next;
      s_ready <= (ram_cnt_next < CNT_W'(DEPTH));
    end
  end

  // In-flight read tracker; clearing it on reset drops any stale returns.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= (vld_sr << 1) | READ_LATENCY'(issue);
    end
  end

  // Prefetch buffer pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ob_wp  <= '0;
      ob_rp  <= '0;
      ob_cnt <= '0;
    end else begin
      if (ob_wr) ob_wp <= (ob_wp == OBP_W'(OB_DEPTH - 1)) ? '0 : ob_wp + OBP_W'(1);
      if (pop) ob_rp <= (ob_rp == OBP_W'(OB_DEPTH - 1)) ? '0 : ob_rp + OBP_W'(1);
      ob_cnt <= ob_cnt + OBC_W'(ob_wr) - OBC_W'(pop);
    end
  end

  // Prefetch buffer storage; no reset needed since occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (ob_wr) ob_mem[ob_wp] <= ram_dout;
  end

endmodule
